// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared types and constants for the median window transmitter
//
// Purpose: FSM state encoding, the serial window length and the WAIT
// timeout length used by median_window_tx.
// Ports: none (package).
package median_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  // 3x3 window streamed one pixel per cycle
  localparam int WIN_LEN = 9;

  // WAIT cycles tolerated before giving up on the median filter
  localparam int TIMEOUT = 64;

endpackage

// File: rtl/median_window_tx_if.sv
// rtl/median_window_tx_if.sv - pixel, median-filter and result signal bundle
//
// Purpose: groups the raster input, the serial link to the external
// median filter and the result/status outputs.
// Ports (slave = median_window_tx view):
//   in : PIX_IN[W], PIX_VAL, PIX_SOF, MED_DO[W], MED_DSO
//   out: PIX_RDY, MED_DI[W], MED_DSI, RES[W], RES_VAL, ERR
interface median_window_tx_if #(
  parameter int W = 8
);

  logic [W-1:0] PIX_IN;
  logic         PIX_VAL;
  logic         PIX_SOF;
  logic         PIX_RDY;
  logic [W-1:0] MED_DI;
  logic         MED_DSI;
  logic [W-1:0] MED_DO;
  logic         MED_DSO;
  logic [W-1:0] RES;
  logic         RES_VAL;
  logic         ERR;

  modport slave (
    input  PIX_IN, PIX_VAL, PIX_SOF, MED_DO, MED_DSO,
    output PIX_RDY, MED_DI, MED_DSI, RES, RES_VAL, ERR
  );

  modport master (
    output PIX_IN, PIX_VAL, PIX_SOF, MED_DO, MED_DSO,
    input  PIX_RDY, MED_DI, MED_DSI, RES, RES_VAL, ERR
  );

endinterface

// File: rtl/line_buf.sv
// rtl/line_buf.sv - single-port LINE x W line buffer, read-before-write
//
// Purpose: holds one image line. The read port is combinational so the
// old word at addr_i is visible in the same cycle it gets overwritten.
// Ports:
//   clk_i       in   clock
//   addr_i      in   pixel column
//   we_i        in   write enable
//   wr_data_i   in   word written at addr_i on the rising edge
//   rd_data_o   out  current (pre-write) word at addr_i
module line_buf #(
  parameter int W    = 8,
  parameter int LINE = 640,
  localparam int AW  = $clog2(LINE)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [W-1:0]  wr_data_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] mem_q [LINE];

  assign rd_data_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/median_window_tx.sv
// rtl/median_window_tx.sv - 3x3 raster window serializer for an external median filter
//
// Purpose: builds a 3x3 window over the incoming raster using two line
// buffers, streams each interior window (row-major) to the median filter
// and captures the returned median. Optional WAIT timeout is enabled by
// defining MEDIAN_WINDOW_TX_TIMEOUT_EN; otherwise ERR is tied low.
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   bus        slave modport of median_window_tx_if (pixel in, filter link,
//              RES/RES_VAL result, ERR sticky timeout flag)
module median_window_tx
  import median_pkg::*;
#(
  parameter int W    = 8,
  parameter int LINE = 640
) (
  input  logic                  CLK,
  input  logic                  RST,
  median_window_tx_if.slave     bus
);

  localparam int CW = $clog2(LINE);
  localparam int IW = $clog2(WIN_LEN);

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [1:0]      row_q, row_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    res_q, res_d;
  logic            res_val_q, res_val_d;
  logic [W-1:0]    win_q [WIN_LEN];

  logic            accept;
  logic            win_valid;
  logic [CW-1:0]   cur_col;
  logic [1:0]      cur_row;
  logic [W-1:0]    l0_rd;
  logic [W-1:0]    l1_rd;
  logic            med_dsi;
  logic [W-1:0]    med_di;

`ifdef MEDIAN_WINDOW_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            err_q, err_d;
`endif

  assign accept = bus.PIX_VAL && (state_q == IDLE);

  // A start-of-frame pixel restarts the raster position immediately
  assign cur_col   = bus.PIX_SOF ? '0 : col_q;
  assign cur_row   = bus.PIX_SOF ? 2'd0 : row_q;
  assign win_valid = (cur_row == 2'd2) && (cur_col >= CW'(2));

  // line0 holds the previous line, line1 the one before it; the word read
  // from line0 cascades into line1 at the same column
  line_buf #(.W(W), .LINE(LINE)) u_line0 (
    .clk_i     (CLK),
    .addr_i    (cur_col),
    .we_i      (accept),
    .wr_data_i (bus.PIX_IN),
    .rd_data_o (l0_rd)
  );

  line_buf #(.W(W), .LINE(LINE)) u_line1 (
    .clk_i     (CLK),
    .addr_i    (cur_col),
    .we_i      (accept),
    .wr_data_i (l0_rd),
    .rd_data_o (l1_rd)
  );

  // Raster position; row saturates at 2 since only "at least two lines
  // above" matters for window validity
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == CW'(LINE - 1)) begin
        col_d = '0;
        row_d = (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  // Window stored row-major: index 3*r + c, column 2 is the newest
  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_q[3*r]   <= win_q[3*r+1];
        win_q[3*r+1] <= win_q[3*r+2];
      end
      win_q[2] <= l1_rd;
      win_q[5] <= l0_rd;
      win_q[8] <= bus.PIX_IN;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    res_d     = res_q;
    res_val_d = 1'b0;
    med_dsi   = 1'b0;
    med_di    = '0;
`ifdef MEDIAN_WINDOW_TX_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
`ifdef MEDIAN_WINDOW_TX_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        if (accept && win_valid) begin
          state_d = SEND;
        end
      end
      SEND: begin
        med_dsi = 1'b1;
        med_di  = win_q[idx_q];
        if (idx_q == IW'(WIN_LEN - 1)) begin
          state_d = WAIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      WAIT: begin
        if (bus.MED_DSO) begin
          res_d     = bus.MED_DO;
          res_val_d = 1'b1;
          state_d   = IDLE;
        end
`ifdef MEDIAN_WINDOW_TX_TIMEOUT_EN
        else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      idx_q     <= '0;
      res_q     <= '0;
      res_val_q <= 1'b0;
`ifdef MEDIAN_WINDOW_TX_TIMEOUT_EN
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      idx_q     <= idx_d;
      res_q     <= res_d;
      res_val_q <= res_val_d;
`ifdef MEDIAN_WINDOW_TX_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus.PIX_RDY = (state_q == IDLE);
  assign bus.MED_DSI = med_dsi;
  assign bus.MED_DI  = med_di;
  assign bus.RES     = res_q;
  assign bus.RES_VAL = res_val_q;
`ifdef MEDIAN_WINDOW_TX_TIMEOUT_EN
  assign bus.ERR     = err_q;
`else
  assign bus.ERR     = 1'b0;
`endif

endmodule
